// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative IEEE-754 single-precision divider, restoring, truncating
// Special operands finish through a fast path; finite operands take 25 divide cycles plus one normalize cycle.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Div_Out,
  output logic        Invalid,
  output logic        Div_Zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state, state_next;
  logic               sign;
  logic [24:0]        rem;
  logic [23:0]        dvs;
  logic signed [9:0]  exp_r;
  logic [24:0]        quo;
  logic [4:0]         cnt;

  logic [7:0]         a_exp, b_exp;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               special, spec_inv, spec_dz, op_sign;
  logic [31:0]        spec_res;
  logic signed [9:0]  exp_n;
  logic [22:0]        mant;
  logic [24:0]        dvs_ext;

  assign a_exp   = A[30:23];
  assign b_exp   = B[30:23];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (A[22:0] == 23'h0);
  assign b_inf   = (b_exp == 8'hFF) && (B[22:0] == 23'h0);
  assign a_nan   = (a_exp == 8'hFF) && (A[22:0] != 23'h0);
  assign b_nan   = (b_exp == 8'hFF) && (B[22:0] != 23'h0);
  assign op_sign = A[31] ^ B[31];
  assign special = a_zero | b_zero | (a_exp == 8'hFF) | (b_exp == 8'hFF);
  assign dvs_ext = {1'b0, dvs};

  // Fast-path result; the if-chain order is the rule priority.
  always_comb begin
    spec_res = {op_sign, 31'h0};
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = 32'h7FC00000;
      spec_inv = 1'b1;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC00000;
      spec_inv = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res = {op_sign, 8'hFF, 23'h0};
      spec_dz  = 1'b1;
    end else if (a_inf) begin
      spec_res = {op_sign, 8'hFF, 23'h0};
    end
  end

  always_comb begin
    exp_n = quo[24] ? exp_r : (exp_r - 10'sd1);
    mant  = quo[24] ? quo[23:1] : quo[22:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'd0) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      rem      <= '0;
      dvs      <= '0;
      exp_r    <= '0;
      quo      <= '0;
      cnt      <= '0;
      Div_Out  <= 32'h0;
      Invalid  <= 1'b0;
      Div_Zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign <= op_sign;
            if (special) begin
              Div_Out  <= spec_res;
              Invalid  <= spec_inv;
              Div_Zero <= spec_dz;
            end else begin
              rem   <= {2'b01, A[22:0]};
              dvs   <= {1'b1, B[22:0]};
              exp_r <= signed'({2'b00, a_exp}) - signed'({2'b00, b_exp}) + 10'sd127;
              quo   <= '0;
              cnt   <= 5'd24;
            end
          end
        end
        DIVIDE: begin
          // Remainder stays below the divisor after each step, so the shift never overflows.
          if (rem >= dvs_ext) begin
            rem <= (rem - dvs_ext) << 1;
            quo <= {quo[23:0], 1'b1};
          end else begin
            rem <= rem << 1;
            quo <= {quo[23:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        NORM: begin
          Invalid  <= 1'b0;
          Div_Zero <= 1'b0;
          if (exp_n >= 10'sd255)
            Div_Out <= {sign, 8'hFF, 23'h0};
          else if (exp_n <= 10'sd0)
            Div_Out <= {sign, 31'h0};
          else
            Div_Out <= {sign, exp_n[7:0], mant};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - self-checking bench for fp_div_seq against an arithmetic reference model
module tb_fp_div_seq;

  logic        clk, rst_n, start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] Div_Out;
  logic        Invalid, Div_Zero;

  int errors = 0;
  int checks = 0;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Div_Out(Div_Out), .Invalid(Invalid), .Div_Zero(Div_Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: a, b, quotient, invalid, divzero, latency in edges after the start edge.
  logic [31:0] da [12] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                           32'h7FC00001, 32'h00000000, 32'h3F800000, 32'h00400000, 32'h7F000000, 32'h00800000};
  logic [31:0] db [12] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000,
                           32'h3F800000, 32'hC0000000, 32'hFF800000, 32'h3F800000, 32'h3E800000, 32'h40000000};
  logic [31:0] dq [12] = '{32'h40400000, 32'h3EAAAAAA, 32'hBEAAAAAA, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                           32'h7FC00000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000};
  logic        dinv [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  logic        ddz  [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int          dlat [12] = '{26, 26, 26, 0, 0, 0, 0, 0, 0, 0, 26, 26};

  // Reference: {invalid, divzero, result}; quotient is the true ratio truncated to 24 significant bits.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s, az, bz, ai, bi, an, bn;
    logic [63:0] ma, mb, m;
    int e;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (an || bn) return {2'b10, 32'h7FC00000};
    if ((az && bz) || (ai && bi)) return {2'b10, 32'h7FC00000};
    if (bz && !ai) return {2'b01, s, 8'hFF, 23'h0};
    if (ai) return {2'b00, s, 8'hFF, 23'h0};
    if (az || bi) return {2'b00, s, 31'h0};
    ma = {40'h0, 1'b1, a[22:0]};
    mb = {40'h0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (ma >= mb) m = (ma << 23) / mb;
    else begin
      m = (ma << 24) / mb;
      e = e - 1;
    end
    if (e >= 255) return {2'b00, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b00, s, 31'h0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    int r;
    logic [7:0] ex;
    r = $urandom_range(0, 9);
    case (r)
      0: return {1'($urandom), 31'h0};
      1: return {1'($urandom), 8'hFF, 23'h0};
      2: return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      3: return {1'($urandom), 8'h00, 23'($urandom)};
      default: begin
        ex = 8'($urandom_range(1, 254));
        if (r > 6) ex = 8'($urandom_range(100, 154));
        return {1'($urandom), ex, 23'($urandom)};
      end
    endcase
  endfunction

  // Issues one start and watches done; lat is the number of edges after the start edge, -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                        output logic inv, output logic dz, output int lat, output bit hs_ok);
    lat = -1; hs_ok = 1'b1; res = '0; inv = 1'b0; dz = 1'b0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    for (int k = 0; k < 40; k++) begin
      if (!busy) hs_ok = 1'b0;
      if (done) begin
        lat = k; res = Div_Out; inv = Invalid; dz = Div_Zero;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (done || busy) hs_ok = 1'b0;
    if (lat >= 0 && (Div_Out !== res || Invalid !== inv || Div_Zero !== dz)) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, Div_Out, Invalid, Div_Zero} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h nv=%b dz=%b, want all zero", busy, done, Div_Out, Invalid, Div_Zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] res; logic inv, dz; int lat; bit ok;
    for (int i = 0; i < 12; i++) begin
      run_op(da[i], db[i], res, inv, dz, lat, ok);
      checks++;
      if (res !== dq[i] || inv !== dinv[i] || dz !== ddz[i]) begin
        errors++;
        $display("FAIL directed_%0d %h/%h: got %h nv=%b dz=%b, want %h nv=%b dz=%b",
                 i, da[i], db[i], res, inv, dz, dq[i], dinv[i], ddz[i]);
      end
      checks++;
      if (lat !== dlat[i]) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d, want %0d", i, lat, dlat[i]);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL directed_handshake_%0d: busy/done/hold got bad, want busy through done and outputs held", i);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res; logic inv, dz; int lat, want_lat; bit ok;
    logic [33:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp_v = ref_div(a, b);
      want_lat = (a[30:23] == 0 || a[30:23] == 8'hFF || b[30:23] == 0 || b[30:23] == 8'hFF) ? 0 : 26;
      run_op(a, b, res, inv, dz, lat, ok);
      checks++;
      if ({inv, dz, res} !== exp_v || lat !== want_lat || !ok) begin
        errors++;
        $display("FAIL random_%0d %h/%h: got %h nv=%b dz=%b lat=%0d hs=%b, want %h nv=%b dz=%b lat=%0d",
                 i, a, b, res, inv, dz, lat, ok, exp_v[31:0], exp_v[33], exp_v[32], want_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    logic [31:0] outs[$];
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 56; k++) begin
      start = (k == 0 || k == 5 || k == 27 || k == 28);
      if (k == 0) begin A = 32'h40C00000; B = 32'h40000000; end
      else begin A = 32'h3F800000; B = 32'h40400000; end
      @(posedge clk);
      @(negedge clk);
      if (done) begin dones.push_back(k); outs.push_back(Div_Out); end
      if (busy !== ((k <= 26) || (k >= 28 && k <= 54))) busy_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (dones.size() != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, want 2", dones.size());
    end else begin
      checks++;
      if (dones[0] != 26 || dones[1] != 54) begin
        errors++;
        $display("FAIL b2b_done_cycles: got %0d,%0d, want 26,54", dones[0], dones[1]);
      end
      checks++;
      if (outs[0] !== 32'h40400000 || outs[1] !== 32'h3EAAAAAA) begin
        errors++;
        $display("FAIL b2b_results: got %h,%h, want 40400000,3eaaaaaa", outs[0], outs[1]);
      end
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL b2b_busy: got wrong busy profile, want high for edges 0-26 and 28-54");
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic inv, dz; int lat; bit ok; bit saw_done;
    run_op(32'h7FC00001, 32'h3F800000, res, inv, dz, lat, ok);
    checks++;
    if (Invalid !== 1'b1 || Div_Out !== 32'h7FC00000) begin
      errors++;
      $display("FAIL pre_reset_nan: got %h nv=%b, want 7fc00000 nv=1", Div_Out, Invalid);
    end
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Div_Out, Invalid, Div_Zero} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b out=%h nv=%b dz=%b, want all zero", busy, done, Div_Out, Invalid, Div_Zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abandoned_op: got done/busy after reset, want none");
    end
    run_op(32'h40C00000, 32'h40000000, res, inv, dz, lat, ok);
    checks++;
    if (res !== 32'h40400000 || inv !== 1'b0 || dz !== 1'b0 || lat !== 26 || !ok) begin
      errors++;
      $display("FAIL post_reset_op: got %h nv=%b dz=%b lat=%0d hs=%b, want 40400000 0 0 26 1", res, inv, dz, lat, ok);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative single-precision IEEE-754 divider for the F-extension execute stage. It computes `A / B` by restoring mantissa division, one quotient bit per cycle. Special operands resolve on a fast path. It sits beside the combinational multiplier in the FPU and uses the same rules:

- canonical NaN `32'h7FC00000`;
- signed zero and infinity handling;
- subnormals flushed to zero;
- round-toward-zero (truncation).

The FPU controller drives it with a start/busy/done handshake.

## Interface
Parameters: none.

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  request; sampled only in IDLE
- `A`  input  32  dividend, IEEE-754 single
- `B`  input  32  divisor, IEEE-754 single
- `busy`  output  1  high from the cycle after an accepted start until the cycle done is high (inclusive)
- `done`  output  1  one-cycle pulse; result valid
- `Div_Out`  output  32  quotient; holds until the next accepted start
- `Invalid`  output  1  NV flag, valid with done, held with Div_Out
- `Div_Zero`  output  1  DZ flag, valid with done, held with Div_Out

## Operation
States: IDLE, DIVIDE, NORM, DONE.

Start acceptance:
- `start` high in IDLE latches A and B and the sign `A[31]^B[31]`.
- `start` in any other state is ignored; operands are not re-latched.

Classification at start:
- exponent 0 is zero (subnormals included);
- exponent FF with frac 0 is inf;
- exponent FF with frac ≠ 0 is NaN.

Special path (IDLE→DONE), first match wins:
1. Any NaN → `7FC00000`, Invalid=1.
2. 0/0 or inf/inf → `7FC00000`, Invalid=1.
3. Finite nonzero / 0 → `{s,FF,0}`, Div_Zero=1.
4. inf / finite → `{s,FF,0}`.
5. 0 / nonzero or finite / inf → `{s,31'h0}`.

Normal path (IDLE→DIVIDE):
- Setup:
  - `R = {1'b0,1,Ma}` (25 bits);
  - `D = {1,Mb}` (24 bits);
  - `E = Ea − Eb + 127` (10-bit signed);
  - `q = 0` (25 bits);
  - iteration counter = 24.
- Each DIVIDE cycle:
  - if `R ≥ D`, then `R ← R − D` and the q bit is 1; otherwise the q bit is 0;
  - `q ← {q[23:0], bit}`;
  - `R ← R << 1`;
  - decrement the counter.
- After 25 iterations, go to NORM.
- NORM:
  - if `q[24]`, mantissa = `q[23:1]` and E is unchanged;
  - else mantissa = `q[22:0]` and `E ← E − 1`.
  - The remainder is discarded (truncation).
- Packing, then go to DONE:
  - `E ≥ 255` → `{s,FF,0}`;
  - `E ≤ 0` → `{s,31'h0}`, flushed;
  - else `{s,E[7:0],mant}`.
- Normal results have flags 0.

DONE: `done`=1 for exactly one cycle, then IDLE. A `start` in the DONE cycle is ignored.

Reset, asynchronous, any state:
- state → IDLE;
- busy=0, done=0;
- Div_Out=`32'h0`, Invalid=0, Div_Zero=0;
- internal R, D, q, E, counter cleared.
- An in-flight operation is abandoned, and no done is produced for it.

## Timing
- Cycle 0 is the edge at which `start` is sampled high in IDLE.
- Special-path latency:
  - edge 0 → DONE;
  - done, Div_Out and flags are visible in cycle 1;
  - busy=1 in cycle 1.
- Normal-path latency:
  - DIVIDE occupies cycles 1–25;
  - NORM is cycle 26;
  - DONE is cycle 27: done=1, Div_Out valid.
  - busy is high in cycles 1–27.
- Next accepted start: earliest at cycle 28 (IDLE again); back-to-back throughput is 1 op / 28 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A/B may change after cycle 0 without effect.

## Test plan
- 6.0/2.0: `A=40C00000`, `B=40000000`, start → done exactly at cycle 27, `Div_Out=40400000`, flags 0, busy high cycles 1–27.
- 1.0/3.0 (truncation): `3F800000 / 40400000` → `3EAAAAAA`. Also `BF800000 / 40400000` → `BEAAAAAA`.
- Specials, each with done at cycle 1:
  - `3F800000 / 00000000` → `7F800000`, Div_Zero=1;
  - `80000000 / 00000000` → `7FC00000`, Invalid=1;
  - `7F800000 / 7F800000` → `7FC00000`, Invalid=1;
  - `7FC00001 / 3F800000` → `7FC00000`, Invalid=1;
  - `00000000 / C0000000` → `80000000`;
  - `3F800000 / FF800000` → `80000000`;
  - `00400000 / 3F800000` (subnormal) → `00000000`.
- Range:
  - `7F000000 / 3E800000` → `7F800000` (overflow), flags 0;
  - `00800000 / 40000000` → `00000000` (underflow flush).
- Handshake: pulse start again at cycles 5 and 27 during an operation → ignored, single done at 27, result unchanged. A new start at cycle 28 is accepted, with done at cycle 55.
- Reset mid-op: deassert rst_n at cycle 12 for 2 cycles → outputs zero immediately and no done appears. A fresh `40C00000/40000000` afterwards completes correctly in 27 cycles.
